// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master drives the operand beats and the result backpressure; the slave is the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic                     cin;
  logic                     sub;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         sum;
  logic                     cout;
  logic                     ovf;
  logic [WIDTH/GROUP-1:0]   grp_g;
  logic [WIDTH/GROUP-1:0]   grp_p;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, grp_g, grp_p
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, grp_g, grp_p
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers per-bit generate/propagate; stage 2 resolves group lookahead into the result.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_adder_if.slave  bus
);
  localparam int unsigned NGRP = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_width_check
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic             c0_q, c0_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [NGRP-1:0]  grp_g_q, grp_g_d, grp_p_q, grp_p_d;

  logic             s2_en;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   c;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic             run_c, grp_c, gk, pk;

  assign s2_en        = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_en;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    b_eff      = bus.sub ? ~bus.b : bus.b;
    s1_valid_d = s1_valid_q;
    g_d        = g_q;
    p_d        = p_q;
    c0_d       = c0_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      g_d        = bus.a & b_eff;
      p_d        = bus.a ^ b_eff;
      c0_d       = bus.sub | bus.cin;
    end else if (s2_en) begin
      s1_valid_d = 1'b0;
    end
  end

  // Group carries chain through G/P only; bits inside a group are resolved from that group's carry-in.
  always_comb begin
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = c0_q;
    run_c = 1'b0;
    gk    = 1'b0;
    pk    = 1'b1;
    c[0]  = c0_q;
    for (int unsigned k = 0; k < NGRP; k++) begin
      gk    = 1'b0;
      pk    = 1'b1;
      run_c = grp_c;
      for (int unsigned i = 0; i < GROUP; i++) begin
        gk = g_q[k*GROUP+i] | (p_q[k*GROUP+i] & gk);
        pk = pk & p_q[k*GROUP+i];
        if (i < GROUP - 1) begin
          run_c = g_q[k*GROUP+i] | (p_q[k*GROUP+i] & run_c);
          c[k*GROUP+i+1] = run_c;
        end
      end
      grp_g[k] = gk;
      grp_p[k] = pk;
      grp_c    = gk | (pk & grp_c);
      c[(k+1)*GROUP] = grp_c;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    grp_g_d     = grp_g_q;
    grp_p_d     = grp_p_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d   = p_q ^ c[WIDTH-1:0];
        cout_d  = c[WIDTH];
        ovf_d   = c[WIDTH] ^ c[WIDTH-1];
        grp_g_d = grp_g;
        grp_p_d = grp_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      g_q         <= '0;
      p_q         <= '0;
      c0_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      grp_g_q     <= '0;
      grp_p_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      g_q         <= g_d;
      p_q         <= p_d;
      c0_q        <= c0_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      grp_g_q     <= grp_g_d;
      grp_p_q     <= grp_p_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.grp_g     = grp_g_q;
  assign bus.grp_p     = grp_p_q;
endmodule
